// File: rtl/phase_sequencer.sv
// Four-phase instruction-cycle sequencer. Generates registered one-hot
// phase strobes (Q1 fetch, Q2 operand read, Q3 ALU, Q4 write-back) from a
// single clock domain. Handles branch flush, stall at the instruction
// boundary, and halt/wake.
// Optional feature: define INSTR_COUNT_EN to build the retired-instruction
// counter; otherwise instr_count is tied to zero.
module phase_sequencer #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             wake,
  output logic             instFetch,
  output logic             dataFetch,
  output logic             aluResults,
  output logic             saveFiles,
  output logic             wr_en,
  output logic             pc_en,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {StStartup, StRun, StFlush, StGap, StHalt} state_e;

  localparam int unsigned StartEdges = 4 * RESET_CYCLES;
  localparam int unsigned StartW     = (StartEdges > 0) ? $clog2(StartEdges + 1) : 1;

  state_e              state_q;
  logic [1:0]          phase_q;
  logic [StartW-1:0]   start_cnt_q;
  logic                flush_pending_q;
  logic [3:0]          strobe_q;
  logic                flush_q;
  logic                wr_en_q;
  logic                pc_en_q;
  logic                halted_q;

  logic                in_cycle;
  logic                at_q4;
  logic                start_cycle;

  // Decide whether the coming edge launches a new instruction cycle at Q1.
  always_comb begin
    in_cycle    = (state_q == StRun) || (state_q == StFlush);
    at_q4       = in_cycle && (phase_q == 2'd3);
    start_cycle = (at_q4 && !halt_req && !stall) ||
                  ((state_q == StGap) && !stall) ||
                  ((state_q == StHalt) && wake) ||
                  ((state_q == StStartup) && (start_cnt_q == StartW'(StartEdges)));
  end

  // Sequencer state and registered strobes; strobes default low every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StStartup;
      phase_q         <= 2'd0;
      start_cnt_q     <= '0;
      flush_pending_q <= 1'b0;
      strobe_q        <= 4'b0000;
      flush_q         <= 1'b0;
      wr_en_q         <= 1'b0;
      pc_en_q         <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      strobe_q <= 4'b0000;
      flush_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      pc_en_q  <= 1'b0;
      halted_q <= 1'b0;
      if (start_cycle) begin
        // A pending flush turns the whole next cycle into a refetch.
        state_q         <= flush_pending_q ? StFlush : StRun;
        phase_q         <= 2'd0;
        strobe_q        <= 4'b0001;
        flush_q         <= flush_pending_q;
        flush_pending_q <= 1'b0;
      end else begin
        unique case (state_q)
          StStartup: start_cnt_q <= start_cnt_q + StartW'(1);
          StRun, StFlush: begin
            if (phase_q == 2'd3) begin
              // Q4 exit without continuing: halt wins over stall.
              if (halt_req) begin
                state_q  <= StHalt;
                halted_q <= 1'b1;
              end else begin
                state_q <= StGap;
              end
            end else begin
              phase_q  <= phase_q + 2'd1;
              strobe_q <= 4'b0001 << (phase_q + 2'd1);
              flush_q  <= (state_q == StFlush);
              if (phase_q == 2'd2) begin
                wr_en_q <= (state_q == StRun);
                pc_en_q <= 1'b1;
              end
              // Branches resolved inside a flush cycle are wrong-path.
              if ((phase_q == 2'd2) && branch_taken && (state_q == StRun)) begin
                flush_pending_q <= 1'b1;
              end
            end
          end
          StGap: begin
          end
          StHalt: halted_q <= 1'b1;
          default: state_q <= StStartup;
        endcase
      end
    end
  end

  assign instFetch  = strobe_q[0];
  assign dataFetch  = strobe_q[1];
  assign aluResults = strobe_q[2];
  assign saveFiles  = strobe_q[3];
  assign flush      = flush_q;
  assign wr_en      = wr_en_q;
  assign pc_en      = pc_en_q;
  assign halted     = halted_q;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Retire on the edge that completes a non-flush Q4.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if ((state_q == StRun) && (phase_q == 2'd3)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule
